// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths and register-index helpers for the write-back stage
package wb_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 1 << ADDR_W;
  localparam int CNT_W    = 32;
  localparam int ZERO_REG = 0;

  // Index 0 is hardwired to zero: writes are dropped and reads return 0
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return a == ZERO_REG[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/wb_regfile_sel.sv
// rtl/wb_regfile_sel.sv - write-back source mux, also usable by EX forwarding
module wb_regfile_sel
  import wb_regfile_pkg::*;
(
  input  logic              i_mem_to_reg,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic [DATA_W-1:0] o_wb_data
);

  assign o_wb_data = i_mem_to_reg ? i_mem_data : i_alu_data;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage with architectural register file and commit counter
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              w_write_reg,
  input  logic              w_mem_to_reg,
  input  logic [DATA_W-1:0] data_from_mem,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] reg_des,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  wb_count
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [CNT_W-1:0]  r_wb_count;

  logic [ADDR_W-1:0] w_wa;
  logic              w_we;
  logic              w_byp;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_unused_des;

  // Only the low index bits of the destination are architectural
  assign w_wa         = reg_des[ADDR_W-1:0];
  assign w_unused_des = ^reg_des[DATA_W-1:ADDR_W];
  assign w_we         = w_write_reg && !is_zero_reg(w_wa);
  // Bypass is suppressed in reset so reads return 0 while the array is held clear
  assign w_byp        = rst && w_we;

  wb_regfile_sel u_sel (
    .i_mem_to_reg (w_mem_to_reg),
    .i_mem_data   (data_from_mem),
    .i_alu_data   (alu_result),
    .o_wb_data    (w_wb_data)
  );

  assign wb_data  = w_wb_data;
  assign wb_count = r_wb_count;

  // Commit the selected write-back value into the register array
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[w_wa] <= w_wb_data;
    end
  end

  // Count committed writes; wraps silently at 2**32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_count <= '0;
    end else if (w_we) begin
      r_wb_count <= r_wb_count + 1'b1;
    end
  end

  // Read port A: zero register, then same-cycle bypass, then array
  always_comb begin
    rs_data = '0;
    if (is_zero_reg(rs_addr)) begin
      rs_data = '0;
    end else if (w_byp && (rs_addr == w_wa)) begin
      rs_data = w_wb_data;
    end else begin
      rs_data = r_regs[rs_addr];
    end
  end

  // Read port B: same priority as port A
  always_comb begin
    rt_data = '0;
    if (is_zero_reg(rt_addr)) begin
      rt_data = '0;
    end else if (w_byp && (rt_addr == w_wa)) begin
      rt_data = w_wb_data;
    end else begin
      rt_data = r_regs[rt_addr];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for the write-back register file
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        w_write_reg;
  logic        w_mem_to_reg;
  logic [31:0] data_from_mem;
  logic [31:0] alu_result;
  logic [31:0] reg_des;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic [31:0] wb_count;

  localparam int SEL_RS  = 0;
  localparam int SEL_RT  = 1;
  localparam int SEL_WB  = 2;
  localparam int SEL_CNT = 3;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  chk_t chk_q[$];
  int   total = 0;
  int   bad   = 0;
  int   req   = 0;

  wb_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .w_write_reg   (w_write_reg),
    .w_mem_to_reg  (w_mem_to_reg),
    .data_from_mem (data_from_mem),
    .alu_result    (alu_result),
    .reg_des       (reg_des),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .wb_data       (wb_data),
    .wb_count      (wb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: on each sample request pop every pending expectation and compare
  initial begin
    chk_t        e;
    logic [31:0] act;
    forever begin
      @(req);
      while (chk_q.size() > 0) begin
        e = chk_q.pop_front();
        case (e.sel)
          SEL_RS:  act = rs_data;
          SEL_RT:  act = rt_data;
          SEL_WB:  act = wb_data;
          default: act = wb_count;
        endcase
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
        end
      end
    end
  end

  task automatic expect_out(input int sel, input logic [31:0] exp, input string nm);
    chk_t e;
    e.sel = sel;
    e.exp = exp;
    e.nm  = nm;
    chk_q.push_back(e);
  endtask

  task automatic sample();
    #1;
    req++;
    #1;
    if (chk_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL monitor_timeout: got %0d pending expected 0", chk_q.size());
      chk_q.delete();
    end
  endtask

  task automatic drive_wr(input logic we, input logic m2r, input logic [31:0] mem,
                          input logic [31:0] alu, input logic [31:0] des);
    w_write_reg   = we;
    w_mem_to_reg  = m2r;
    data_from_mem = mem;
    alu_result    = alu;
    reg_des       = des;
  endtask

  initial begin
    rst     = 1'b0;
    rs_addr = '0;
    rt_addr = '0;
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 1. reset state on both ports for every register
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      expect_out(SEL_RS, 32'h0, $sformatf("reset_rs_r%0d", i));
      expect_out(SEL_RT, 32'h0, $sformatf("reset_rt_r%0d", 31 - i));
      sample();
    end
    expect_out(SEL_CNT, 32'h0, "reset_count");
    sample();

    // 2. ALU write to r5
    @(negedge clk);
    drive_wr(1'b1, 1'b0, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 32'd5);
    rs_addr = 5'd5;
    expect_out(SEL_WB, 32'hDEAD_BEEF, "alu_wb_data");
    expect_out(SEL_RS, 32'hDEAD_BEEF, "alu_bypass_rs");
    sample();
    @(negedge clk);
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    expect_out(SEL_RS, 32'hDEAD_BEEF, "alu_stored_r5");
    expect_out(SEL_CNT, 32'd1, "alu_count");
    sample();

    // 3. load write to r7 with bypass on port B
    drive_wr(1'b1, 1'b1, 32'h1234_5678, 32'h5555_0000, 32'd7);
    rt_addr = 5'd7;
    expect_out(SEL_WB, 32'h1234_5678, "load_wb_data");
    expect_out(SEL_RT, 32'h1234_5678, "load_bypass_rt");
    sample();
    @(negedge clk);
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    expect_out(SEL_RT, 32'h1234_5678, "load_stored_r7");
    expect_out(SEL_CNT, 32'd2, "load_count");
    sample();

    // 4. zero register writes are dropped, including aliased upper bits
    drive_wr(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd0);
    rs_addr = 5'd0;
    expect_out(SEL_RS, 32'h0, "zero_no_bypass");
    sample();
    @(negedge clk);
    drive_wr(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0020);
    expect_out(SEL_RS, 32'h0, "zero_after_write");
    expect_out(SEL_CNT, 32'd2, "zero_count_a");
    sample();
    @(negedge clk);
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rt_addr = 5'd0;
    expect_out(SEL_RT, 32'h0, "zero_alias_rt");
    expect_out(SEL_CNT, 32'd2, "zero_count_b");
    sample();

    // 5. disabled write: no bypass, no update
    drive_wr(1'b0, 1'b0, 32'hFFFF_0000, 32'hAAAA_AAAA, 32'd5);
    rs_addr = 5'd5;
    expect_out(SEL_RS, 32'hDEAD_BEEF, "dis_no_bypass");
    sample();
    @(negedge clk);
    expect_out(SEL_RS, 32'hDEAD_BEEF, "dis_kept_r5");
    expect_out(SEL_CNT, 32'd2, "dis_count");
    sample();

    // both ports on the write target
    drive_wr(1'b1, 1'b0, 32'h0, 32'h0000_0055, 32'd9);
    rs_addr = 5'd9;
    rt_addr = 5'd9;
    expect_out(SEL_RS, 32'h0000_0055, "dual_bypass_rs");
    expect_out(SEL_RT, 32'h0000_0055, "dual_bypass_rt");
    sample();
    @(negedge clk);

    // 6. writes to r1..r3 then async reset between edges
    for (int i = 1; i <= 3; i++) begin
      drive_wr(1'b1, 1'b0, 32'h0, 32'h1000_0000 + 32'(i), 32'(i));
      @(negedge clk);
    end
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rs_addr = 5'd2;
    rt_addr = 5'd3;
    expect_out(SEL_RS, 32'h1000_0002, "pre_rst_r2");
    expect_out(SEL_RT, 32'h1000_0003, "pre_rst_r3");
    expect_out(SEL_CNT, 32'd6, "pre_rst_count");
    sample();
    rst = 1'b0;
    expect_out(SEL_RS, 32'h0, "async_rst_r2");
    expect_out(SEL_RT, 32'h0, "async_rst_r3");
    expect_out(SEL_CNT, 32'h0, "async_rst_count");
    sample();
    @(negedge clk);
    rst = 1'b1;
    rs_addr = 5'd1;
    rt_addr = 5'd5;
    expect_out(SEL_RS, 32'h0, "post_rst_r1");
    expect_out(SEL_RT, 32'h0, "post_rst_r5");
    sample();

    // 7. counter wrap
    @(negedge clk);
    force dut.r_wb_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_wb_count;
    drive_wr(1'b1, 1'b1, 32'hCAFE_F00D, 32'h0, 32'd4);
    @(negedge clk);
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rs_addr = 5'd4;
    expect_out(SEL_RS, 32'hCAFE_F00D, "wrap_r4");
    expect_out(SEL_CNT, 32'h0, "wrap_count");
    sample();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
